// File: rtl/al422_frame_writer.sv
// Write-side sequencer for the AL422 frame FIFO: resyncs on SOF, pulses write-reset, writes FRAME_BYTES bytes.
// Latency: SOF accepted at edge N -> wrst_n low N+1..N+RST_CYCLES, first write N+RST_CYCLES+1; 1 byte/clk after.
// Backpressure: in_ready low while resetting the FIFO pointer, writing the held SOF byte, and in DONE.
module al422_frame_writer #(
    parameter int FRAME_BYTES = 6144,
    parameter int RST_CYCLES  = 2
) (
    input  logic       in_clk,
    input  logic       in_nrst,
    input  logic [7:0] in_data,
    input  logic       in_sof,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] al422_din,
    output logic       al422_we_n,
    output logic       al422_wrst_n,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        WAIT_SOF,
        WRST,
        WFIRST,
        WRITE,
        DONE
    } state_t;

    state_t         state_q, state_nxt;
    logic [CW-1:0]  cnt_q, cnt_nxt, cnt_inc;
    logic [RW-1:0]  rcnt_q, rcnt_nxt;
    logic [7:0]     hold_q, hold_nxt;
    logic [7:0]     din_nxt;
    logic           we_n_nxt, wrst_n_nxt, done_nxt, err_nxt;
    logic           accept;

    assign in_ready = (state_q == WAIT_SOF) || (state_q == WRITE);
    assign accept   = in_valid & in_ready;
    assign cnt_inc  = cnt_q + CW'(1);

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state_q      <= WAIT_SOF;
            cnt_q        <= '0;
            rcnt_q       <= '0;
            hold_q       <= 8'h00;
            al422_din    <= 8'h00;
            al422_we_n   <= 1'b1;
            al422_wrst_n <= 1'b1;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            rcnt_q       <= rcnt_nxt;
            hold_q       <= hold_nxt;
            al422_din    <= din_nxt;
            al422_we_n   <= we_n_nxt;
            al422_wrst_n <= wrst_n_nxt;
            frame_done   <= done_nxt;
            frame_err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        rcnt_nxt   = rcnt_q;
        hold_nxt   = hold_q;
        din_nxt    = al422_din;
        we_n_nxt   = 1'b1;
        wrst_n_nxt = 1'b1;
        err_nxt    = 1'b0;
        // The write that is on the FIFO pins right now completes the frame.
        done_nxt   = ~al422_we_n & (cnt_q == CW'(FRAME_BYTES));

        case (state_q)
            WAIT_SOF: begin
                if (accept && in_sof) begin
                    hold_nxt   = in_data;
                    cnt_nxt    = '0;
                    rcnt_nxt   = '0;
                    wrst_n_nxt = 1'b0;
                    state_nxt  = WRST;
                end
            end
            WRST: begin
                // Outputs are registered, so the first write is launched as the pulse ends.
                if (rcnt_q == RW'(RST_CYCLES - 1)) begin
                    we_n_nxt  = 1'b0;
                    din_nxt   = hold_q;
                    cnt_nxt   = CW'(1);
                    state_nxt = WFIRST;
                end else begin
                    rcnt_nxt   = rcnt_q + RW'(1);
                    wrst_n_nxt = 1'b0;
                end
            end
            WFIRST: begin
                state_nxt = (FRAME_BYTES == 1) ? DONE : WRITE;
            end
            WRITE: begin
                if (accept) begin
                    if (in_sof) begin
                        hold_nxt   = in_data;
                        err_nxt    = 1'b1;
                        cnt_nxt    = '0;
                        rcnt_nxt   = '0;
                        wrst_n_nxt = 1'b0;
                        state_nxt  = WRST;
                    end else begin
                        we_n_nxt = 1'b0;
                        din_nxt  = in_data;
                        cnt_nxt  = cnt_inc;
                        if (cnt_inc == CW'(FRAME_BYTES)) begin
                            state_nxt = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = WAIT_SOF;
            end
            default: begin
                state_nxt = WAIT_SOF;
            end
        endcase
    end

endmodule

// File: tb/tb_al422_frame_writer.sv
// Bench for al422_frame_writer: scoreboard of expected FIFO writes plus per-scenario event counts and SOF latency checks.
module tb_al422_frame_writer;

    localparam int FB = 4;
    localparam int RC = 2;

    logic       in_clk = 1'b0;
    logic       in_nrst;
    logic [7:0] in_data;
    logic       in_sof;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] al422_din;
    logic       al422_we_n;
    logic       al422_wrst_n;
    logic       frame_done;
    logic       frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int sof_edge = -1;
    int n_done   = 0;
    int n_err    = 0;
    int n_wr     = 0;
    int wr_in_frame = 0;
    logic prev_we_n = 1'b1;
    logic [7:0] exp_q[$];

    al422_frame_writer #(.FRAME_BYTES(FB), .RST_CYCLES(RC)) dut (
        .in_clk      (in_clk),
        .in_nrst     (in_nrst),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .al422_din   (al422_din),
        .al422_we_n  (al422_we_n),
        .al422_wrst_n(al422_wrst_n),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 in_clk = ~in_clk;
    always @(posedge in_clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every write and checks SOF-relative timing.
    always @(negedge in_clk) begin
        if (in_nrst === 1'b1) begin
            int d;
            d = cyc - sof_edge;
            if (sof_edge >= 0) begin
                if (d >= 0 && d < RC) begin
                    n_checks++;
                    if (al422_wrst_n !== 1'b0 || in_ready !== 1'b0)
                        $display("FAIL wrst_pulse d=%0d: wrst_n=%b ready=%b, required wrst_n=0 ready=0", d, al422_wrst_n, in_ready);
                    else n_pass++;
                end else if (d == RC) begin
                    n_checks++;
                    if (al422_wrst_n !== 1'b1 || al422_we_n !== 1'b0 || in_ready !== 1'b0)
                        $display("FAIL first_write_lat: wrst_n=%b we_n=%b ready=%b, required 1 0 0", al422_wrst_n, al422_we_n, in_ready);
                    else n_pass++;
                end else if (d == RC + 1) begin
                    n_checks++;
                    if (in_ready !== 1'b1)
                        $display("FAIL ready_rise: ready=%b, required 1", in_ready);
                    else n_pass++;
                    sof_edge = -1;
                end
            end
            if (al422_wrst_n === 1'b0) wr_in_frame = 0;
            if (al422_we_n === 1'b0) begin
                n_wr++;
                wr_in_frame++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: din=%h, required no write", al422_din);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (al422_din !== e || al422_wrst_n !== 1'b1)
                        $display("FAIL write_data: din=%h wrst_n=%b, required din=%h wrst_n=1", al422_din, al422_wrst_n, e);
                    else n_pass++;
                end
            end
            if (frame_done === 1'b1) begin
                n_done++;
                n_checks++;
                if (prev_we_n !== 1'b0 || wr_in_frame != FB)
                    $display("FAIL done_timing: prev_we_n=%b writes=%0d, required 0 and %0d", prev_we_n, wr_in_frame, FB);
                else n_pass++;
            end
            if (frame_err === 1'b1) begin
                n_err++;
                n_checks++;
                if (d != 0)
                    $display("FAIL err_timing: cycles after sof=%0d, required 0", d);
                else n_pass++;
            end
            prev_we_n = al422_we_n;
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic sof, input logic exp_wr);
        bit ok;
        ok = 0;
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge in_clk);
            if (in_ready === 1'b1) begin
                ok = 1;
                if (sof) sof_edge = cyc + 1;
                if (exp_wr) exp_q.push_back(d);
            end
            @(posedge in_clk);
            #1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: byte %h not accepted in 50 cycles, required acceptance", d);
        end
    endtask

    task automatic end_check(input string name, input int done0, input int err0, input int wr0,
                             input int exp_done, input int exp_err, input int exp_wr);
        idle(10);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_missing_writes: %0d left, required 0", name, exp_q.size());
        else n_pass++;
        n_checks++;
        if (n_done - done0 != exp_done || n_err - err0 != exp_err || n_wr - wr0 != exp_wr)
            $display("FAIL %s_counts: done=%0d err=%0d wr=%0d, required %0d %0d %0d", name,
                     n_done - done0, n_err - err0, n_wr - wr0, exp_done, exp_err, exp_wr);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1 || al422_we_n !== 1'b1 || al422_wrst_n !== 1'b1)
            $display("FAIL %s_idle: ready=%b we_n=%b wrst_n=%b, required 1 1 1", name, in_ready, al422_we_n, al422_wrst_n);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if (al422_we_n !== 1'b1 || al422_wrst_n !== 1'b1 || al422_din !== 8'h00 ||
            frame_done !== 1'b0 || frame_err !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_values: we_n=%b wrst_n=%b din=%h done=%b err=%b ready=%b, required 1 1 00 0 0 1",
                     al422_we_n, al422_wrst_n, al422_din, frame_done, frame_err, in_ready);
        else n_pass++;
    endtask

    task automatic test_full_frame();
        int d0, e0, w0;
        d0 = n_done; e0 = n_err; w0 = n_wr;
        send(8'h11, 1, 1);
        send(8'h22, 0, 1);
        send(8'h33, 0, 1);
        send(8'h44, 0, 1);
        end_check("full_frame", d0, e0, w0, 1, 0, 4);
    endtask

    task automatic test_presync_drop();
        int d0, e0, w0;
        d0 = n_done; e0 = n_err; w0 = n_wr;
        send(8'hAA, 0, 0);
        send(8'hBB, 0, 0);
        send(8'hC1, 1, 1);
        send(8'hC2, 0, 1);
        send(8'hC3, 0, 1);
        send(8'hC4, 0, 1);
        end_check("presync_drop", d0, e0, w0, 1, 0, 4);
    endtask

    task automatic test_short_frame();
        int d0, e0, w0;
        d0 = n_done; e0 = n_err; w0 = n_wr;
        send(8'h01, 1, 1);
        send(8'h02, 0, 1);
        send(8'h10, 1, 1);
        send(8'h20, 0, 1);
        send(8'h30, 0, 1);
        send(8'h40, 0, 1);
        end_check("short_frame", d0, e0, w0, 1, 1, 6);
    endtask

    task automatic test_backpressure();
        int d0, e0, w0;
        d0 = n_done; e0 = n_err; w0 = n_wr;
        send(8'h71, 1, 1); idle(1);
        send(8'h72, 0, 1); idle(1);
        send(8'h73, 0, 1); idle(1);
        send(8'h74, 0, 1); idle(1);
        send(8'h7A, 0, 0);
        send(8'h7B, 0, 0);
        end_check("backpressure", d0, e0, w0, 1, 0, 4);
    endtask

    task automatic test_reset_midframe();
        int d0, e0, w0;
        send(8'h61, 1, 1);
        send(8'h62, 0, 1);
        idle(1);
        #2;
        in_nrst = 1'b0;
        #1;
        sof_edge = -1;
        wr_in_frame = 0;
        prev_we_n = 1'b1;
        n_checks++;
        if (al422_we_n !== 1'b1 || al422_wrst_n !== 1'b1 || al422_din !== 8'h00 || in_ready !== 1'b1)
            $display("FAIL async_reset: we_n=%b wrst_n=%b din=%h ready=%b, required 1 1 00 1",
                     al422_we_n, al422_wrst_n, al422_din, in_ready);
        else n_pass++;
        @(posedge in_clk);
        #1;
        in_nrst = 1'b1;
        d0 = n_done; e0 = n_err; w0 = n_wr;
        send(8'h55, 0, 0);
        end_check("post_reset_drop", d0, e0, w0, 0, 0, 0);
        d0 = n_done; e0 = n_err; w0 = n_wr;
        send(8'h81, 1, 1);
        send(8'h82, 0, 1);
        send(8'h83, 0, 1);
        send(8'h84, 0, 1);
        end_check("post_reset_frame", d0, e0, w0, 1, 0, 4);
    endtask

    initial begin
        in_nrst  = 1'b0;
        in_data  = 8'h00;
        in_sof   = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        test_reset();
        in_nrst = 1'b1;
        idle(2);
        test_full_frame();
        test_presync_drop();
        test_short_frame();
        test_backpressure();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
